// File: rtl/instr_encoder_if.sv
// Instruction-encoder bus: symbolic instruction handshake from the host side
// plus the instruction-memory write/read port.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Host/memory side
  modport master (
    output in_valid, op_sel, rs, rt, rd, imm, target, mem_rdata,
    input  in_ready, mem_we, mem_re, mem_addr, mem_wdata
  );

  // Encoder side
  modport slave (
    input  in_valid, op_sel, rs, rt, rd, imm, target, mem_rdata,
    output in_ready, mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs one symbolic MIPS instruction per handshake into a
// 32-bit word and writes it to instruction memory at an auto-incrementing
// address. Optional build macro INSTR_ENCODER_READBACK_EN adds a read-back
// verify pass after every write.
module instr_encoder #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  instr_encoder_if.slave  bus,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            err_illegal,
  output logic            err_verify
);

`ifdef INSTR_ENCODER_READBACK_EN
  typedef enum logic [1:0] {IDLE, WRITE, RD_REQ, RD_CMP} state_t;
`else
  typedef enum logic {IDLE, WRITE} state_t;
`endif

  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc;
  logic              legal;
  logic              accept;
  logic              do_clear;

  assign full = (count == DEPTH_CNT);

  // Combinational encoding of the presented mnemonic and fields
  always_comb begin
    legal = 1'b1;
    enc   = '0;
    case (bus.op_sel)
      4'd0:    enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100000};
      4'd1:    enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100010};
      4'd2:    enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100100};
      4'd3:    enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100101};
      4'd4:    enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100111};
      4'd5:    enc = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b101010};
      4'd6:    enc = {6'b001000, bus.rs, bus.rt, bus.imm};
      4'd7:    enc = {6'b100011, bus.rs, bus.rt, bus.imm};
      4'd8:    enc = {6'b101011, bus.rs, bus.rt, bus.imm};
      4'd9:    enc = {6'b000100, bus.rs, bus.rt, bus.imm};
      4'd10:   enc = {6'b000010, bus.target};
      default: legal = 1'b0;
    endcase
  end

  // Next-state and handshake/strobe outputs
  always_comb begin
    state_n      = state;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_re   = 1'b0;
    accept       = 1'b0;
    do_clear     = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = !full;
        if (clear) begin
          do_clear = 1'b1;
        end else if (bus.in_valid && !full) begin
          accept = 1'b1;
          if (legal) state_n = WRITE;
        end
      end
      WRITE: begin
        bus.mem_we = 1'b1;
`ifdef INSTR_ENCODER_READBACK_EN
        state_n = RD_REQ;
`else
        state_n = IDLE;
`endif
      end
`ifdef INSTR_ENCODER_READBACK_EN
      RD_REQ: begin
        bus.mem_re = 1'b1;
        state_n    = RD_CMP;
      end
      RD_CMP: state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  // State, pointer, count, latched word/address and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      count         <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      err_illegal   <= 1'b0;
    end else begin
      state <= state_n;
      if (do_clear) begin
        ptr         <= '0;
        count       <= '0;
        err_illegal <= 1'b0;
      end
      if (accept) begin
        if (legal) begin
          // address/word registered at accept so they are stable for the
          // WRITE cycle and stay put for the readback request
          bus.mem_addr  <= ptr;
          bus.mem_wdata <= enc;
        end else begin
          err_illegal <= 1'b1;
        end
      end
      if (state == WRITE) begin
        ptr   <= ptr + 1'b1;
        count <= count + 1'b1;
      end
    end
  end

`ifdef INSTR_ENCODER_READBACK_EN
  logic err_vf;

  // Sticky read-back mismatch flag
  always_ff @(posedge clk) begin
    if (reset) begin
      err_vf <= 1'b0;
    end else if (do_clear) begin
      err_vf <= 1'b0;
    end else if (state == RD_CMP && bus.mem_rdata != bus.mem_wdata) begin
      err_vf <= 1'b1;
    end
  end

  assign err_verify = err_vf;
`else
  assign err_verify = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (ADDR_W=6 and ADDR_W=2) share one
// stimulus stream; each is compared every cycle against a transaction-level
// reference model, with directed scenarios followed by random traffic.
module tb_instr_encoder;

`ifdef INSTR_ENCODER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, clr, vld;
  logic [3:0]  op;
  logic [4:0]  f_rs, f_rt, f_rd;
  logic [15:0] f_imm;
  logic [25:0] f_tgt;
  logic        corrupt_en;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(6)) b6 ();
  instr_encoder_if #(.ADDR_W(2)) b2 ();

  logic [6:0] cnt6;
  logic [2:0] cnt2;
  logic full6, full2, eil6, eil2, evf6, evf2;

  instr_encoder #(.ADDR_W(6)) u6 (
    .clk(clk), .reset(rst), .clear(clr), .bus(b6),
    .count(cnt6), .full(full6), .err_illegal(eil6), .err_verify(evf6)
  );
  instr_encoder #(.ADDR_W(2)) u2 (
    .clk(clk), .reset(rst), .clear(clr), .bus(b2),
    .count(cnt2), .full(full2), .err_illegal(eil2), .err_verify(evf2)
  );

  assign b6.in_valid = vld;   assign b2.in_valid = vld;
  assign b6.op_sel   = op;    assign b2.op_sel   = op;
  assign b6.rs       = f_rs;  assign b2.rs       = f_rs;
  assign b6.rt       = f_rt;  assign b2.rt       = f_rt;
  assign b6.rd       = f_rd;  assign b2.rd       = f_rd;
  assign b6.imm      = f_imm; assign b2.imm      = f_imm;
  assign b6.target   = f_tgt; assign b2.target   = f_tgt;

  // Instruction memories with one-cycle read latency; optional bit-0
  // corruption on reads of address 0
  logic [31:0] mem6 [64];
  logic [31:0] mem2 [4];
  logic [31:0] rd6, rd2;
  assign b6.mem_rdata = rd6;
  assign b2.mem_rdata = rd2;

  always @(posedge clk) begin
    if (b6.mem_we) mem6[b6.mem_addr] <= b6.mem_wdata;
    if (b2.mem_we) mem2[b2.mem_addr] <= b2.mem_wdata;
    rd6 <= mem6[b6.mem_addr] ^ {31'b0, corrupt_en && b6.mem_addr == 6'd0};
    rd2 <= mem2[b2.mem_addr] ^ {31'b0, corrupt_en && b2.mem_addr == 2'd0};
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: per instance, a transaction timeline.
  // m_ph counts cycles into the current transaction (0 = idle/ready).
  int          dep   [2] = '{64, 4};
  int          m_cnt [2];
  int          m_ph  [2];
  int          m_addr[2];
  logic [31:0] m_wd  [2];
  bit          m_eil [2];
  bit          m_evf [2];

  function automatic logic [31:0] ref_word(input int o, input int s, input int t,
                                           input int d, input int im, input int tg);
    int funct [6] = '{32, 34, 36, 37, 39, 42};
    int opc   [4] = '{8, 35, 43, 4};
    if (o <= 5)  return 32'((s << 21) + (t << 16) + (d << 11) + funct[o]);
    if (o <= 9)  return 32'((opc[o-6] << 26) + (s << 21) + (t << 16) + im);
    return 32'((2 << 26) + tg);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_ph[i] = 0; m_addr[i] = 0; m_wd[i] = 0;
        m_eil[i] = 0; m_evf[i] = 0;
      end else if (m_ph[i] == 0) begin
        if (clr) begin
          m_cnt[i] = 0; m_eil[i] = 0; m_evf[i] = 0;
        end else if (vld && m_cnt[i] < dep[i]) begin
          if (op > 10) m_eil[i] = 1;
          else begin
            m_wd[i]   = ref_word(int'(op), int'(f_rs), int'(f_rt), int'(f_rd),
                                 int'(f_imm), int'(f_tgt));
            m_addr[i] = m_cnt[i] % dep[i];
            m_ph[i]   = 1;
          end
        end
      end else if (m_ph[i] == 1) begin
        m_cnt[i]++;
        m_ph[i] = RB ? 2 : 0;
      end else if (m_ph[i] == 2) begin
        m_ph[i] = 3;
      end else begin
        if (corrupt_en && m_addr[i] == 0) m_evf[i] = 1;
        m_ph[i] = 0;
      end
    end
  endtask

  task automatic compare();
    logic [31:0] a_rdy, a_we, a_re, a_addr, a_wd, a_cnt, a_full, a_eil, a_evf;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        a_rdy = 32'(b6.in_ready); a_we = 32'(b6.mem_we); a_re = 32'(b6.mem_re);
        a_addr = 32'(b6.mem_addr); a_wd = b6.mem_wdata; a_cnt = 32'(cnt6);
        a_full = 32'(full6); a_eil = 32'(eil6); a_evf = 32'(evf6);
      end else begin
        a_rdy = 32'(b2.in_ready); a_we = 32'(b2.mem_we); a_re = 32'(b2.mem_re);
        a_addr = 32'(b2.mem_addr); a_wd = b2.mem_wdata; a_cnt = 32'(cnt2);
        a_full = 32'(full2); a_eil = 32'(eil2); a_evf = 32'(evf2);
      end
      check($sformatf("u%0d.in_ready", i), a_rdy, 32'(m_ph[i] == 0 && m_cnt[i] < dep[i]));
      check($sformatf("u%0d.mem_we", i), a_we, 32'(m_ph[i] == 1));
      check($sformatf("u%0d.mem_re", i), a_re, 32'(m_ph[i] == 2));
      check($sformatf("u%0d.mem_addr", i), a_addr, 32'(m_addr[i]));
      check($sformatf("u%0d.mem_wdata", i), a_wd, m_wd[i]);
      check($sformatf("u%0d.count", i), a_cnt, 32'(m_cnt[i]));
      check($sformatf("u%0d.full", i), a_full, 32'(m_cnt[i] == dep[i]));
      check($sformatf("u%0d.err_illegal", i), a_eil, 32'(m_eil[i]));
      check($sformatf("u%0d.err_verify", i), a_evf, 32'(m_evf[i]));
    end
  endtask

  // One clock: advance the model over the coming edge, then sample outputs
  task automatic tick();
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20 && !(m_ph[0] == 0 && m_ph[1] == 0); n++) tick();
  endtask

  // Present one instruction for a single cycle; returns in the cycle after accept
  task automatic issue(input int o, input int s, input int t, input int d,
                       input int im, input int tg);
    op = 4'(o); f_rs = 5'(s); f_rt = 5'(t); f_rd = 5'(d);
    f_imm = 16'(im); f_tgt = 26'(tg);
    vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; vld = 1'b0; op = '0;
    f_rs = '0; f_rt = '0; f_rd = '0; f_imm = '0; f_tgt = '0;
    corrupt_en = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // ADD r3 = r1 + r2
    issue(0, 1, 2, 3, 0, 0);
    check("add.we", 32'(b6.mem_we), 32'd1);
    check("add.addr", 32'(b6.mem_addr), 32'd0);
    check("add.wdata", b6.mem_wdata, 32'h00221820);
    tick();
    check("add.count", 32'(cnt6), 32'd1);
    if (!RB) check("add.ready_k2", 32'(b6.in_ready), 32'd1);
    wait_idle();

    issue(7, 0, 8, 0, 16'h0004, 0);
    check("lw.wdata", b6.mem_wdata, 32'h8C080004);
    check("lw.addr", 32'(b6.mem_addr), 32'd1);
    wait_idle();
    issue(8, 29, 31, 0, 16'h0008, 0);
    check("sw.wdata", b6.mem_wdata, 32'hAFBF0008);
    check("sw.addr", 32'(b6.mem_addr), 32'd2);
    wait_idle();
    issue(9, 1, 2, 0, 16'hFFFF, 0);
    check("beq.wdata", b6.mem_wdata, 32'h1022FFFF);
    check("beq.addr", 32'(b6.mem_addr), 32'd3);
    wait_idle();
    tick();
    check("small.full", 32'(full2), 32'd1);
    check("small.ready", 32'(b2.in_ready), 32'd0);
    issue(10, 0, 0, 0, 0, 26'h0000010);
    check("j.wdata", b6.mem_wdata, 32'h08000010);
    check("j.addr", 32'(b6.mem_addr), 32'd4);
    check("small.no_we", 32'(b2.mem_we), 32'd0);
    wait_idle();

    issue(12, 0, 0, 0, 0, 0);
    check("ill.err", 32'(eil6), 32'd1);
    check("ill.count", 32'(cnt6), 32'd5);
    check("ill.ready", 32'(b6.in_ready), 32'd1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr.err", 32'(eil6), 32'd0);
    check("clr.count", 32'(cnt6), 32'd0);
    check("clr.small_ready", 32'(b2.in_ready), 32'd1);
    issue(0, 1, 2, 3, 0, 0);
    check("clr.addr", 32'(b6.mem_addr), 32'd0);
    check("clr.small_we", 32'(b2.mem_we), 32'd1);
    check("clr.small_addr", 32'(b2.mem_addr), 32'd0);
    wait_idle();

    // Reset landing on the WRITE cycle
    issue(3, 4, 5, 6, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstw.we", 32'(b6.mem_we), 32'd0);
    check("rstw.count", 32'(cnt6), 32'd0);
    tick();

    corrupt_en = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      rst   = ($urandom_range(0, 99) == 0);
      clr   = ($urandom_range(0, 29) == 0);
      vld   = ($urandom_range(0, 9) < 6);
      op    = 4'($urandom_range(0, 12));
      f_rs  = 5'($urandom); f_rt = 5'($urandom); f_rd = 5'($urandom);
      f_imm = 16'($urandom); f_tgt = 26'($urandom);
      tick();
    end
    rst = 1'b0; clr = 1'b0; vld = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and program loader: accepts one symbolic instruction per handshake (mnemonic code plus register, immediate and target fields) and packs it into a 32-bit MIPS word. It writes each word into the instruction memory at an auto-incrementing address. It is the encoding counterpart of the single-cycle control unit: every opcode/funct pair that unit decodes is produced here. It sits between the board's switch/host input logic and the instruction memory write port.

## Interface
- ADDR_W, default 6: instruction memory word-address width; DEPTH = 2**ADDR_W words.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  restarts loading at address 0 and clears status; honored only in IDLE.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept an instruction.
- op_sel  in  4  mnemonic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLT, 6 ADDI, 7 LW, 8 SW, 9 BEQ, 10 J; 11–15 illegal.
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate / branch offset.
- target  in  26  jump target field.
- mem_we  out  1  instruction memory write strobe.
- mem_re  out  1  memory read strobe (readback build only; tied 0 otherwise).
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  encoded instruction.
- mem_rdata  in  32  memory read data; one-cycle synchronous read latency.
- count  out  ADDR_W+1  number of words written since reset/clear.
- full  out  1  count == DEPTH.
- err_illegal  out  1  sticky: an illegal op_sel was accepted.
- err_verify  out  1  sticky: readback mismatch (0 without readback).

## Operation
- Encoding, registered at accept:
  - R-type (codes 0–5): {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - Funct values: ADD 100000, SUB 100010, AND 100100, OR 100101, NOR 100111, SLT 101010.
  - I-type: {op, rs, rt, imm}. Opcodes: ADDI 001000, LW 100011, SW 101011, BEQ 000100.
  - J: {000010, target}.
  - Fields not used by the format are ignored.
- States: IDLE, WRITE, RD_REQ, RD_CMP. RD_REQ and RD_CMP exist only with the readback macro.
- IDLE:
  - in_ready = !full.
  - On in_valid && in_ready with a legal op_sel: latch the word and go to WRITE.
  - On an illegal op_sel: accept it, set err_illegal, write nothing, and stay in IDLE.
  - clear has priority over in_valid. It zeroes the pointer, count, err_illegal and err_verify, and accepts nothing that cycle.
- WRITE:
  - mem_we = 1, mem_addr = ptr, mem_wdata = latched word.
  - ptr and count increment at the end of the cycle.
  - Next state: IDLE, or RD_REQ with readback.
- RD_REQ: mem_re = 1, mem_addr = address just written.
- RD_CMP: compare mem_rdata with the latched word; on mismatch set err_verify. Next state: IDLE.
- Full:
  - When count reaches DEPTH, in_ready stays 0 until clear or reset.
  - ptr wraps to 0 at the same point, but no further writes occur.
- in_valid held while in_ready = 0 is ignored. The inputs need not stay stable after the accept cycle.
- clear outside IDLE is ignored. The caller holds it until in_ready returns, or until IDLE is reached if full.

## Timing
- Reset values: state IDLE, in_ready 1, mem_we 0, mem_re 0, mem_addr 0, mem_wdata 0, count 0, full 0, err_illegal 0, err_verify 0.
- mem_addr and mem_wdata hold their last values outside WRITE and RD_REQ.
- Without readback:
  - Accept at edge k, mem_we high in cycle k+1, in_ready high again in k+2.
  - Throughput is 1 instruction per 2 cycles.
- With readback:
  - Cycle k+1 WRITE, k+2 RD_REQ, k+3 RD_CMP; err_verify is visible in k+4.
  - in_ready high in k+4.
- Illegal op_sel: err_illegal is visible the cycle after accept, and in_ready stays 1.
- count/full update in the cycle after WRITE. full asserts the cycle after the DEPTH-th write, and in_ready drops with it.
- Reset in any state returns to reset values the next cycle. A pending write or readback is abandoned, with no mem_we in the reset cycle.

## Configuration
- INSTR_ENCODER_READBACK_EN defined: RD_REQ/RD_CMP states are included, mem_re is driven, and err_verify is functional.
- Not defined: WRITE returns directly to IDLE, and mem_re and err_verify are constant 0.

## Test plan
- ADD rs=1 rt=2 rd=3 -> mem_we one cycle, addr 0, wdata 0x00221820; count 1; in_ready back 2 cycles after accept.
- LW rs=0 rt=8 imm=0x0004, then SW rs=29 rt=31 imm=0x0008, then BEQ rs=1 rt=2 imm=0xFFFF, then J target=0x0000010 -> expected writes:
  - 0x8C080004 @1
  - 0xAFBF0008 @2
  - 0x1022FFFF @3
  - 0x08000010 @4
- op_sel=12 -> no mem_we, err_illegal=1, count unchanged; then clear -> err_illegal=0, count=0, next write at addr 0.
- ADDR_W=2: 4 legal writes -> full=1, in_ready=0; 5th in_valid is ignored with no mem_we; clear -> in_ready=1, and the next write goes to addr 0.
- Reset asserted in the WRITE cycle -> mem_we 0 the next cycle, count 0, all outputs at reset values.
- Readback build, memory model corrupting bit 0 of addr 0 -> err_verify=1 in k+4; an uncorrupted write leaves err_verify=0.
